// File: rtl/mode_counter_pkg.sv
// rtl/mode_counter_pkg.sv - mode encodings and modulus helper for mode_counter
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'b00,
        MODE_GRAY    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_RING    = 2'b11
    } mode_t;

    // Number of distinct indices the counter walks through in a given mode.
    function automatic int unsigned M(mode_t mode, int unsigned width);
        case (mode)
            MODE_BIN, MODE_GRAY: return 32'd1 << width;
            MODE_JOHNSON:        return 32'd2 * width;
            default:             return width;
        endcase
    endfunction

endpackage

// File: rtl/mode_counter_enc.sv
// rtl/mode_counter_enc.sv - combinational index-to-code encoder (binary, Gray, Johnson, ring)
module mode_counter_enc
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] idx_i,
    input  mode_t            mode_i,
    output logic [WIDTH-1:0] code_o
);

    logic [31:0] k;
    logic [31:0] ones_k;
    logic [31:0] ones_all;
    logic [31:0] john_hi;
    logic [31:0] ring;

    always_comb begin
        k        = 32'(idx_i);
        ones_k   = (32'd1 << k) - 32'd1;
        ones_all = (32'd1 << WIDTH) - 32'd1;
        // Only meaningful when k > WIDTH; the zeros shifted in walk up from the LSB.
        john_hi  = ones_all << (k - 32'(WIDTH));
        ring     = 32'd1 << k;
        code_o   = '0;
        case (mode_i)
            MODE_BIN:     code_o = idx_i;
            MODE_GRAY:    code_o = idx_i ^ (idx_i >> 1);
            MODE_JOHNSON: code_o = (k <= 32'(WIDTH)) ? ones_k[WIDTH-1:0] : john_hi[WIDTH-1:0];
            default:      code_o = ring[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - multi-mode up/down counter with registered encoded state, tc and wrap
// Optional load path enabled by defining MODE_COUNTER_LOAD_EN.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MODE_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    input  logic             en,
    input  logic             Y,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] IDX_ONE = WIDTH'(1);

    mode_t            mode_e;
    logic [WIDTH:0]   mod_w;
    logic [WIDTH:0]   mod_m1;
    logic [WIDTH-1:0] last_idx;
    logic             in_range;

    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] q_q, code_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;

    assign mode_e   = mode_t'(mode);
    assign mod_w    = (WIDTH+1)'(M(mode_e, WIDTH));
    assign mod_m1   = mod_w - MOD_ONE;
    assign last_idx = mod_m1[WIDTH-1:0];
    assign in_range = ({1'b0, idx_q} < mod_w);

    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
`ifdef MODE_COUNTER_LOAD_EN
        if (load) begin
            idx_d = ({1'b0, d} < mod_w) ? d : '0;
        end else
`endif
        if (!in_range) begin
            // A mode change can leave the index beyond the new modulus.
            idx_d = '0;
        end else if (en) begin
            if (Y) begin
                if (idx_q == last_idx) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d  = last_idx;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
        end
        tc_d = Y ? (idx_d == last_idx) : (idx_d == '0);
    end

    mode_counter_enc #(
        .WIDTH(WIDTH)
    ) u_enc (
        .idx_i (idx_d),
        .mode_i(mode_e),
        .code_o(code_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            q_q    <= '0;
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            q_q    <= code_d;
            tc_q   <= tc_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign tc   = tc_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter (optionally with MODE_COUNTER_LOAD_EN)
module tb_mode_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         Y;
    logic [1:0]   mode;
    logic [W-1:0] Q;
    logic         tc;
    logic         wrap;
    logic         load;
    logic [W-1:0] d;

    int checks   = 0;
    int failures = 0;
    logic chk    = 1'b0;

    int       m_idx;
    logic [W-1:0] e_q;
    logic     e_tc;
    logic     e_wrap;

    mode_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
`ifdef MODE_COUNTER_LOAD_EN
        .load (load),
        .d    (d),
`endif
        .en   (en),
        .Y    (Y),
        .mode (mode),
        .Q    (Q),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modm(int md);
        case (md)
            0, 1:    return 1 << W;
            2:       return 2 * W;
            default: return W;
        endcase
    endfunction

    // Codes built by walking the register sequence rather than by formula.
    function automatic logic [W-1:0] code_of(int k, int md);
        logic [W-1:0] c;
        c = W'(k);
        case (md)
            0: c = W'(k);
            1: c = c ^ (c >> 1);
            2: begin
                c = '0;
                for (int i = 0; i < k; i++) c = {c[W-2:0], ~c[W-1]};
            end
            default: begin
                c = W'(1);
                for (int i = 0; i < k; i++) c = {c[W-2:0], c[W-1]};
            end
        endcase
        return c;
    endfunction

    function automatic int nxt_idx(int idx, int md, logic e, logic y, logic ld, int dv);
        int mm;
        mm = modm(md);
        if (ld) return (dv < mm) ? dv : 0;
        if (idx >= mm) return 0;
        if (!e) return idx;
        return y ? (idx + 1) % mm : (idx + mm - 1) % mm;
    endfunction

    function automatic logic nxt_wrap(int idx, int md, logic e, logic y, logic ld);
        int mm;
        mm = modm(md);
        if (ld || idx >= mm || !e) return 1'b0;
        return y ? (idx == mm - 1) : (idx == 0);
    endfunction

    function automatic logic nxt_tc(int nidx, int md, logic y);
        return y ? (nidx == modm(md) - 1) : (nidx == 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idx  <= 0;
            e_q    <= '0;
            e_tc   <= 1'b0;
            e_wrap <= 1'b0;
        end else begin
            m_idx  <= nxt_idx(m_idx, int'(mode), en, Y, load, int'(d));
            e_q    <= code_of(nxt_idx(m_idx, int'(mode), en, Y, load, int'(d)), int'(mode));
            e_tc   <= nxt_tc(nxt_idx(m_idx, int'(mode), en, Y, load, int'(d)), int'(mode), Y);
            e_wrap <= nxt_wrap(m_idx, int'(mode), en, Y, load);
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            checks++;
            if (Q !== e_q || tc !== e_tc || wrap !== e_wrap) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got Q=%b tc=%b wrap=%b required Q=%b tc=%b wrap=%b",
                         $time, Q, tc, wrap, e_q, e_tc, e_wrap);
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int gray_tab[5] = '{1, 3, 2, 6, 7};
    int john_tab[8] = '{1, 3, 7, 15, 14, 12, 8, 0};

    initial begin
        reset = 1'b1; en = 1'b0; Y = 1'b1; mode = 2'd0; load = 1'b0; d = '0;
        #1 reset = 1'b0;
        #1;
        lit("rst_q", int'(Q), 0);
        lit("rst_tc", int'(tc), 0);
        lit("rst_wrap", int'(wrap), 0);

        @(negedge clk);
        reset = 1'b1; en = 1'b1; Y = 1'b1; mode = 2'd0;
        cyc();
        lit("first_edge_q", int'(Q), 1);
        chk = 1'b1;

        repeat (14) cyc();
        lit("bin_top_q", int'(Q), 15);
        lit("bin_top_tc", int'(tc), 1);
        cyc();
        lit("bin_wrap_q", int'(Q), 0);
        lit("bin_wrap", int'(wrap), 1);

        Y = 1'b0;
        cyc();
        lit("down_q", int'(Q), 15);
        lit("down_wrap", int'(wrap), 1);

        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            lit("hold_q", int'(Q), 15);
            lit("hold_wrap", int'(wrap), 0);
        end

        en = 1'b1; Y = 1'b1;
        cyc();
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            lit("gray_q", int'(Q), gray_tab[i]);
        end

        mode = 2'd3;
        cyc();
        lit("oor_ring_q", int'(Q), 1);
        lit("oor_ring_wrap", int'(wrap), 0);

        mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            cyc();
            lit("john_q", int'(Q), john_tab[i]);
        end
        lit("john_wrap", int'(wrap), 1);

        mode = 2'd0;
        repeat (12) cyc();
        lit("bin12_q", int'(Q), 12);
        mode = 2'd2;
        cyc();
        lit("oor_john_q", int'(Q), 0);
        lit("oor_john_wrap", int'(wrap), 0);

        mode = 2'd0;
        repeat (9) cyc();
        lit("bin9_q", int'(Q), 9);
        #2 reset = 1'b0;
        #1;
        lit("async_rst_q", int'(Q), 0);
        lit("async_rst_tc", int'(tc), 0);
        lit("async_rst_wrap", int'(wrap), 0);

        @(negedge clk);
        reset = 1'b1; en = 1'b0; mode = 2'd3;
        cyc();
        lit("ring_first_q", int'(Q), 1);

`ifdef MODE_COUNTER_LOAD_EN
        load = 1'b1; d = W'(5); en = 1'b1;
        cyc();
        lit("load_oor_q", int'(Q), 1);
        lit("load_wrap", int'(wrap), 0);
        mode = 2'd0; d = W'(2);
        cyc();
        lit("load_bin_q", int'(Q), 2);
        load = 1'b0;
`endif

        en = 1'b1; Y = 1'b0; mode = 2'd3;
        repeat (2) cyc();
        mode = 2'd1;
        repeat (3) cyc();
        Y = 1'b1;
        repeat (3) cyc();
        chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
